fft_bitrev_reorder: RTL
=======================

Name: fft_bitrev_reorder

Overview:
- Output stage placed directly downstream of the serial 4-point FFT datapath.
- The FFT emits each frame in bit-reversed order. This block captures each frame into a ping-pong buffer and replays it in natural order (X0, X1, X2, X3).
- It accepts a continuous full-rate stream and produces a gap-free output stream.

Parameters:
- n, 8, sample width in bits; matches the FFT datapath width.
- PTS, 4, points per frame; must be a power of 2 and at least 2.
- LOG2PTS, 2, log2(PTS); sets the address and counter width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clear  input  1  reset, asynchronous, active-low.
- din  input  n  FFT output sample, arriving in bit-reversed index order.
- din_valid  input  1  din is valid this cycle.
- din_sof  input  1  qualifies din as sample 0 of a frame; ignored unless din_valid=1.
- dout  output  n  reordered sample, registered.
- dout_valid  output  1  dout is valid this cycle.
- dout_sof  output  1  dout is natural index 0 of a frame.
- overflow  output  1  sticky flag: an input sample was dropped.

Behaviour:
- Reset (clear=0, asynchronous): dout=0, dout_valid=0, dout_sof=0, overflow=0, wcnt=0, wbank=0, rbank=0, full[1:0]=0, reader in IDLE. Memory contents are don't-care.
- Storage: two banks of PTS words each, mem[bank][addr].
- Write side, on each edge with din_valid=1:
  - If din_sof=1, the effective index k=0; otherwise k=wcnt.
  - If full[wbank]=1: the sample is dropped, overflow is set to 1, and wcnt is unchanged.
  - Otherwise: mem[wbank][bitrev(k)] <= din and wcnt <= k+1 (mod PTS).
  - If k=PTS-1: full[wbank] <= 1 and wbank toggles.
- bitrev reverses the LOG2PTS address bits. For PTS=4 the map is 0->0, 1->2, 2->1, 3->3.
- din_sof arriving with wcnt!=0 restarts the frame in the same bank. The partial frame is overwritten and no flag is raised.
- din_valid=0: no write side state changes.
- Reader FSM, states IDLE and READ, counter rcnt:
  - IDLE: if full[rbank]=1 (value before the edge), then at the edge: dout <= mem[rbank][0], dout_valid <= 1, dout_sof <= 1, rcnt <= 1, go to READ. Otherwise dout_valid <= 0 and dout_sof <= 0; dout holds its value.
  - READ with rcnt<PTS: dout <= mem[rbank][rcnt], dout_valid=1, dout_sof=0, rcnt increments. On the edge that emits word PTS-1: full[rbank] <= 0, rbank toggles, go to IDLE.
  - Back-to-back frames: if the other bank's full bit is set when the last word is emitted, the next edge emits its word 0 with no bubble.
- The reader cannot be stalled; output is always one word per cycle while a frame drains.
- Latency: the last input sample of a frame is written at edge T. Natural words 0..PTS-1 appear on edges T+1..T+PTS.
- Throughput: 1 sample/cycle sustained, with no overflow.
- Simultaneous events:
  - The writer setting full[b] and the reader clearing full[b'] on the same edge is legal, since b != b' by construction.
  - The writer completing a bank on the same edge the reader releases that same bank cannot occur: the write would have been dropped because full was set.
- overflow is cleared only by clear.
- dout is a plain copy of the stored sample; no arithmetic or width change.

Test Plan:
- Reset mid-frame: assert clear=0 with 2 of 4 samples written -> all outputs 0 immediately. After release, a fresh frame 10,20,30,40 outputs 10,30,20,40.
- Single frame: din 10,20,30,40 on consecutive edges, first with sof, last at edge T -> dout 10,30,20,40 on T+1..T+4. dout_sof=1 only at T+1; dout_valid=0 before and after.
- Full-rate stream: three back-to-back frames (1,2,3,4), (5,6,7,8), (9,10,11,12) -> 12 consecutive valid outputs 1,3,2,4,5,7,6,8,9,11,10,12, with sof on outputs 1, 5 and 9 and overflow=0.
- Sparse input: frame 10,20,30,40 with din_valid toggling 1,0,1,0 -> same natural-order output 10,30,20,40, starting the cycle after the 4th valid sample.
- Mid-frame resync: samples 1,2 then sof with 10,20,30,40 -> only 10,30,20,40 is output; overflow stays 0.
- Overflow: force full[wbank] by deasserting clear only after loading both banks (test hook), or by writing a 9th sample before any read using bench-forced FSM hold -> the extra sample is dropped, overflow=1 and stays 1 until clear.

Source files
------------

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed 4-point FFT frames into natural order through a
// ping-pong buffer; full-rate input, gap-free output, sticky drop flag.
module fft_bitrev_reorder #(
  parameter int n       = 8,
  parameter int PTS     = 4,
  parameter int LOG2PTS = 2
) (
  input  logic         clk,
  input  logic         clear,
  input  logic [n-1:0] din,
  input  logic         din_valid,
  input  logic         din_sof,
  output logic [n-1:0] dout,
  output logic         dout_valid,
  output logic         dout_sof,
  output logic         overflow
);

  typedef enum logic {IDLE = 1'b0, READ = 1'b1} rd_state_t;

  rd_state_t          state, state_nxt;
  logic [LOG2PTS-1:0] wcnt, wr_k;
  logic [LOG2PTS-1:0] rcnt, rcnt_nxt, rd_addr;
  logic               wbank, rbank;
  logic [1:0]         full, full_nxt;
  logic               wr_ok, wr_done;
  logic               rd_fire, rd_sof, rd_last;
  logic [n-1:0]       mem [2][PTS];

  function automatic logic [LOG2PTS-1:0] bitrev(input logic [LOG2PTS-1:0] a);
    logic [LOG2PTS-1:0] r;
    for (int i = 0; i < LOG2PTS; i++) r[i] = a[LOG2PTS-1-i];
    return r;
  endfunction

  // Write side: a sof forces index 0 so a partial frame is simply overwritten.
  assign wr_k    = din_sof ? '0 : wcnt;
  assign wr_ok   = din_valid && !full[wbank];
  assign wr_done = wr_ok && (wr_k == LOG2PTS'(PTS-1));

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wbank][bitrev(wr_k)] <= din;
  end

  // Reader: IDLE emits word 0 on the same edge it sees a full bank, so
  // back-to-back frames drain with no bubble.
  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    rd_fire   = 1'b0;
    rd_sof    = 1'b0;
    rd_last   = 1'b0;
    rd_addr   = '0;
    case (state)
      IDLE: begin
        if (full[rbank]) begin
          rd_fire   = 1'b1;
          rd_sof    = 1'b1;
          rcnt_nxt  = LOG2PTS'(1);
          state_nxt = READ;
        end
      end
      READ: begin
        rd_fire  = 1'b1;
        rd_addr  = rcnt;
        rcnt_nxt = rcnt + 1'b1;
        if (rcnt == LOG2PTS'(PTS-1)) begin
          rd_last   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Writer and reader always touch different banks' full bits on one edge.
  always_comb begin
    full_nxt = full;
    if (wr_done) full_nxt[wbank] = 1'b1;
    if (rd_last) full_nxt[rbank] = 1'b0;
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
      rcnt  <= '0;
    end else begin
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      wcnt       <= '0;
      wbank      <= 1'b0;
      rbank      <= 1'b0;
      full       <= 2'b00;
      overflow   <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
    end else begin
      full <= full_nxt;
      if (din_valid) begin
        if (full[wbank]) begin
          overflow <= 1'b1;
        end else begin
          wcnt <= wr_k + 1'b1;
          if (wr_done) wbank <= ~wbank;
        end
      end
      if (rd_last) rbank <= ~rbank;
      dout_valid <= rd_fire;
      dout_sof   <= rd_sof;
      if (rd_fire) dout <= mem[rbank][rd_addr];
    end
  end

endmodule
